// File: rtl/alu_chk_pkg.sv
// Shared definitions for the ALU result checker: FSM encoding and MISR defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_chk_pkg;

  // FSM state encoding, kept as plain constants so older tools can consume it
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // CRC-32 polynomial in Galois form, and the signature start value
  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'h00000000;

endpackage

// File: rtl/alu_result_checker_if.sv
// Control, result stream and status bundle between an ALU slice and the checker.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready; the checker side drives in_ready.
interface alu_result_checker_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic [31:0]      golden;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      result;
  logic             busy;
  logic             done;
  logic             pass;
  logic [31:0]      signature;
  logic [CNT_W-1:0] count;

  // Stimulus / control side
  modport master (
    output start, num_samples, golden, in_valid, result,
    input  in_ready, busy, done, pass, signature, count
  );

  // Checker side
  modport slave (
    input  start, num_samples, golden, in_valid, result,
    output in_ready, busy, done, pass, signature, count
  );
endinterface

// File: rtl/alu_result_checker_misr32.sv
// One MISR step: shift left, fold in the polynomial when the MSB falls off, xor data.
// Latency: combinational.
// Backpressure: none.
module misr32 #(
  parameter logic [31:0] POLY = 32'h04C11DB7
) (
  input  logic [31:0] i_sig,
  input  logic [31:0] i_data,
  output logic [31:0] o_sig
);

  logic [31:0] w_fb;

  // Galois feedback term is the polynomial only when the outgoing bit is set
  assign w_fb  = i_sig[31] ? POLY : 32'h0;
  assign o_sig = {i_sig[30:0], 1'b0} ^ w_fb ^ i_data;

endmodule

// File: rtl/alu_result_checker.sv
// Compacts N ALU results into a MISR signature and compares it against a golden value.
// Latency: done/pass register one clock after the final accepted sample.
// Backpressure: in_ready high only while collecting; one transfer per cycle, no skid.
import alu_chk_pkg::*;

module alu_result_checker #(
  parameter logic [31:0] POLY  = DEF_POLY,
  parameter logic [31:0] SEED  = DEF_SEED,
  parameter int          CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_result_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_num;
  logic [31:0]      r_golden;
  logic [31:0]      r_sig;
  logic [CNT_W-1:0] r_count;
  logic             r_done;
  logic             r_pass;

  logic             w_collect;
  logic             w_start_ok;
  logic             w_xfer;
  logic             w_last;
  logic [31:0]      w_sig_next;

  // Start is only honoured when no run is in flight, which also covers a
  // start arriving alongside the final transfer.
  assign w_collect  = (r_state == ST_COLLECT);
  assign w_start_ok = bus.start & ~w_collect;
  assign w_xfer     = bus.in_valid & w_collect;
  assign w_last     = w_xfer & (r_count == (r_num - CNT_ONE));

  misr32 #(.POLY(POLY)) u_misr (
    .i_sig  (r_sig),
    .i_data (bus.result),
    .o_sig  (w_sig_next)
  );

  // Run FSM, sample counter, signature register and registered compare
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_num    <= CNT_ZERO;
      r_golden <= 32'h0;
      r_sig    <= SEED;
      r_count  <= CNT_ZERO;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else if (w_start_ok) begin
      r_num    <= bus.num_samples;
      r_golden <= bus.golden;
      r_sig    <= SEED;
      r_count  <= CNT_ZERO;
      if (bus.num_samples == CNT_ZERO) begin
        // Empty run: the signature is the seed, so compare that right away
        r_state <= ST_DONE;
        r_done  <= 1'b1;
        r_pass  <= (bus.golden == SEED);
      end else begin
        r_state <= ST_COLLECT;
        r_done  <= 1'b0;
        r_pass  <= 1'b0;
      end
    end else if (w_xfer) begin
      r_sig   <= w_sig_next;
      r_count <= r_count + CNT_ONE;
      if (w_last) begin
        r_state <= ST_DONE;
        r_done  <= 1'b1;
        r_pass  <= (w_sig_next == r_golden);
      end
    end
  end

  assign bus.in_ready  = w_collect;
  assign bus.busy      = w_collect;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.signature = r_sig;
  assign bus.count     = r_count;

endmodule
